// File: rtl/main_memory_responder.sv
// Word-granular main-memory responder for the last-level-cache interface.
// One word per handshake; long first-access latency, short latency for sequential follow-on words.
module main_memory_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 65536,
    parameter int FIRST_LATENCY = 4,
    parameter int BURST_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  protocol_error,
    output logic [31:0]           read_count,
    output logic [31:0]           write_count
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (FIRST_LATENCY > BURST_LATENCY) ? FIRST_LATENCY : BURST_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(FIRST_LATENCY - 1);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  op_wr_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  burst_valid_q;
    logic                  last_op_q;
    logic [IDX_W-1:0]      last_idx_q;
    logic                  mem_ready_q;
    logic                  busy_q;
    logic                  protocol_error_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [31:0]           read_count_q;
    logic [31:0]           write_count_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic                  req_any;
    logic                  sequential;
    logic                  held;
    logic                  resp_en;
    logic                  acc_wr;
    logic [IDX_W-1:0]      idx_in;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_data;

    // Address bits above the storage depth and the byte offset are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[ADDR_WIDTH-1:IDX_W+2], mem_address[1:0]};

    // resp_en marks the edge that enters RESP; acc_* select live inputs from IDLE
    // and latched values from WAIT.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        req_any    = mem_read | mem_write;
        idx_in     = mem_address[IDX_W+1:2];
        sequential = burst_valid_q && (mem_write == last_op_q)
                     && (idx_in == IDX_W'(last_idx_q + 1'b1));
        held       = op_wr_q ? mem_write : mem_read;
        resp_en    = 1'b0;
        acc_wr     = op_wr_q;
        acc_idx    = idx_q;
        acc_data   = wdata_q;
        case (state_q)
            IDLE: begin
                acc_wr   = mem_write;
                acc_idx  = idx_in;
                acc_data = mem_write_data;
                resp_en  = req_any && ((sequential ? BURST_LATENCY : FIRST_LATENCY) == 1);
            end
            WAIT:    resp_en = held && (cnt_q == CNT_W'(1));
            default: resp_en = 1'b0;
        endcase
    end

    // NOTE: storage has no reset; only the write enable is gated so reset never writes.
    always_ff @(posedge clk) begin
        if (resp_en && acc_wr && !reset) begin
            mem_q[acc_idx] <= acc_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            op_wr_q          <= 1'b0;
            idx_q            <= '0;
            wdata_q          <= '0;
            burst_valid_q    <= 1'b0;
            last_op_q        <= 1'b0;
            last_idx_q       <= '0;
            mem_ready_q      <= 1'b0;
            busy_q           <= 1'b0;
            protocol_error_q <= 1'b0;
            read_data_q      <= '0;
            read_count_q     <= '0;
            write_count_q    <= '0;
        end else begin
            mem_ready_q <= resp_en;

            if (resp_en) begin
                if (acc_wr) begin
                    write_count_q <= write_count_q + 32'd1;
                end else begin
                    read_data_q  <= mem_q[acc_idx];
                    read_count_q <= read_count_q + 32'd1;
                end
                burst_valid_q <= 1'b1;
                last_idx_q    <= acc_idx;
                last_op_q     <= acc_wr;
            end

            case (state_q)
                IDLE: begin
                    if (!req_any) begin
                        burst_valid_q <= 1'b0;
                    end else begin
                        op_wr_q <= mem_write;
                        idx_q   <= idx_in;
                        wdata_q <= mem_write_data;
                        busy_q  <= 1'b1;
                        if (mem_read && mem_write) begin
                            protocol_error_q <= 1'b1;
                        end
                        if (resp_en) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= sequential ? BURST_CNT : FIRST_CNT;
                        end
                    end
                end
                WAIT: begin
                    if (!held) begin
                        state_q       <= IDLE;
                        burst_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end else if (resp_en) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read_data  = read_data_q;
    assign mem_ready      = mem_ready_q;
    assign busy           = busy_q;
    assign protocol_error = protocol_error_q;
    assign read_count     = read_count_q;
    assign write_count    = write_count_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: latency, bursts, abort, protocol error,
// reset mid-access and address wrap on a 16-word instance.
module tb_main_memory_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_ready, busy, protocol_error;
    logic [31:0] read_count, write_count;

    logic        s_mem_read, s_mem_write;
    logic [31:0] s_mem_address, s_mem_write_data, s_mem_read_data;
    logic        s_mem_ready, s_busy, s_protocol_error;
    logic [31:0] s_read_count, s_write_count;

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clk = ~clk;

    main_memory_responder dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .busy(busy), .protocol_error(protocol_error),
        .read_count(read_count), .write_count(write_count)
    );

    main_memory_responder #(.DEPTH_WORDS(16)) dut_small (
        .clk(clk), .reset(reset),
        .mem_read(s_mem_read), .mem_write(s_mem_write),
        .mem_address(s_mem_address), .mem_write_data(s_mem_write_data),
        .mem_read_data(s_mem_read_data), .mem_ready(s_mem_ready),
        .busy(s_busy), .protocol_error(s_protocol_error),
        .read_count(s_read_count), .write_count(s_write_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns the number of negedges until mem_ready is seen (bounded).
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, output int cnt);
        mem_write      = wr;
        mem_read       = rd;
        mem_address    = addr;
        mem_write_data = wdata;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!mem_ready && cnt < 20);
    endtask

    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_write_data = '0;
        s_mem_read = 1'b0; s_mem_write = 1'b0; s_mem_address = '0; s_mem_write_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_read_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_perr", {31'd0, protocol_error}, 32'd0);
        check("rst_rcnt", read_count, 32'd0);
        check("rst_wcnt", write_count, 32'd0);

        // Wrap on the 16-word instance: 0x40 and 0x00 map to word 0.
        s_mem_write = 1'b1; s_mem_address = 32'h40; s_mem_write_data = 32'h55;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!s_mem_ready && lat < 20);
        check("wrap_wr_lat", lat, 32'd4);
        s_mem_write = 1'b0;
        repeat (2) @(negedge clk);
        s_mem_read = 1'b1; s_mem_address = 32'h00;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!s_mem_ready && lat < 20);
        check("wrap_rd_lat", lat, 32'd4);
        check("wrap_rd_data", s_mem_read_data, 32'h55);
        s_mem_read = 1'b0;

        // Single write then read from idle.
        access(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, lat);
        check("t1_wr_lat", lat, 32'd4);
        check("t1_wcnt", write_count, 32'd1);
        idle();
        access(1'b0, 1'b1, 32'h100, 32'h0, lat);
        check("t1_rd_lat", lat, 32'd4);
        check("t1_rd_data", mem_read_data, 32'hDEADBEEF);
        check("t1_rcnt", read_count, 32'd1);
        idle();

        // Preload 0x40..0x7C as a write burst, then read it back as a burst.
        for (int i = 0; i < 16; i++) begin
            addr = 32'h40 + 32'(4 * i);
            access(1'b1, 1'b0, addr, 32'hC0DE0000 | addr, lat);
            check("pre_wr_lat", lat, (i == 0) ? 32'd4 : 32'd2);
        end
        idle();
        check("pre_wcnt", write_count, 32'd17);
        for (int i = 0; i < 16; i++) begin
            addr = 32'h40 + 32'(4 * i);
            access(1'b0, 1'b1, addr, 32'h0, lat);
            check("burst_rd_lat", lat, (i == 0) ? 32'd4 : 32'd2);
            check("burst_rd_data", mem_read_data, 32'hC0DE0000 | addr);
        end
        idle();
        check("burst_rcnt", read_count, 32'd17);

        // Write then back-to-back read of the same word: op change breaks the burst.
        access(1'b1, 1'b0, 32'h20, 32'hA5A5A5A5, lat);
        check("t3_wr_lat", lat, 32'd4);
        check("t3_rdata_held", mem_read_data, 32'hC0DE007C);
        access(1'b0, 1'b1, 32'h20, 32'h0, lat);
        check("t3_rd_lat", lat, 32'd5);
        check("t3_rd_data", mem_read_data, 32'hA5A5A5A5);
        idle();
        check("t3_wcnt", write_count, 32'd18);
        check("t3_rcnt", read_count, 32'd18);

        // Abort a read in WAIT by dropping mem_read.
        mem_read = 1'b1; mem_address = 32'h80;
        @(negedge clk);
        check("ab_ready_c1", {31'd0, mem_ready}, 32'd0);
        check("ab_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ab_ready_c2", {31'd0, mem_ready}, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        check("ab_ready_c3", {31'd0, mem_ready}, 32'd0);
        check("ab_busy_c3", {31'd0, busy}, 32'd0);
        check("ab_rcnt", read_count, 32'd18);
        check("ab_wcnt", write_count, 32'd18);
        access(1'b0, 1'b1, 32'h84, 32'h0, lat);
        check("ab_next_lat", lat, 32'd4);
        check("ab_next_rcnt", read_count, 32'd19);
        idle();

        // Both requests high: write wins and protocol_error sticks.
        access(1'b1, 1'b1, 32'h10, 32'h1234, lat);
        check("pe_lat", lat, 32'd4);
        check("pe_flag", {31'd0, protocol_error}, 32'd1);
        check("pe_wcnt", write_count, 32'd19);
        idle();
        repeat (3) @(negedge clk);
        check("pe_sticky", {31'd0, protocol_error}, 32'd1);

        // Reset in the middle of a write's WAIT: no write, all status cleared.
        mem_write = 1'b1; mem_address = 32'h10; mem_write_data = 32'h00000BAD;
        repeat (2) @(negedge clk);
        check("rw_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rw_ready", {31'd0, mem_ready}, 32'd0);
        check("rw_busy_clr", {31'd0, busy}, 32'd0);
        check("rw_perr", {31'd0, protocol_error}, 32'd0);
        check("rw_wcnt", write_count, 32'd0);
        check("rw_rcnt", read_count, 32'd0);
        mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        access(1'b0, 1'b1, 32'h10, 32'h0, lat);
        check("rw_rd_lat", lat, 32'd4);
        check("rw_rd_data", mem_read_data, 32'h1234);
        check("rw_rcnt_after", read_count, 32'd1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
